// File: rtl/cache_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writes onto one memory port.
// Define CACHE_ARB_RR_EN for round-robin on simultaneous requests; default gives dcache priority.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst,

    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic [255:0] icache_rdata,
    output logic         icache_resp,

    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [31:0]  dcache_address,
    input  logic [255:0] dcache_wdata,
    output logic [255:0] dcache_rdata,
    output logic         dcache_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        RESP
    } state_t;

    state_t       state;
    logic [31:0]  addr_q;
    logic [255:0] wdata_q;
    logic [255:0] line_q;

    logic icache_req;
    logic dcache_req;
    logic grant_d;

`ifdef CACHE_ARB_RR_EN
    // Set when the most recent grant went to dcache; reset means "icache last".
    logic last_d_q;
`endif

    always_comb begin
        icache_req = icache_read;
        dcache_req = dcache_read | dcache_write;
`ifdef CACHE_ARB_RR_EN
        grant_d = dcache_req & (~icache_req | ~last_d_q);
`else
        grant_d = dcache_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            icache_resp <= 1'b0;
            dcache_resp <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
`ifdef CACHE_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            icache_resp <= 1'b0;
            dcache_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (icache_req || dcache_req) begin
`ifdef CACHE_ARB_RR_EN
                        last_d_q <= grant_d;
`endif
                        if (grant_d) begin
                            addr_q <= dcache_address & 32'hFFFF_FFE0;
                            // A simultaneous read+write is serviced as a write.
                            if (dcache_write) begin
                                wdata_q    <= dcache_wdata;
                                pmem_write <= 1'b1;
                                state      <= D_WRITE;
                            end else begin
                                pmem_read <= 1'b1;
                                state     <= D_READ;
                            end
                        end else begin
                            addr_q    <= icache_address & 32'hFFFF_FFE0;
                            pmem_read <= 1'b1;
                            state     <= I_READ;
                        end
                    end
                end
                I_READ, D_READ: begin
                    if (pmem_resp) begin
                        line_q    <= pmem_rdata;
                        pmem_read <= 1'b0;
                        state     <= RESP;
                        if (state == D_READ) begin
                            dcache_resp <= 1'b1;
                        end else begin
                            icache_resp <= 1'b1;
                        end
                    end
                end
                D_WRITE: begin
                    if (pmem_resp) begin
                        pmem_write  <= 1'b0;
                        dcache_resp <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign icache_rdata = line_q;
    assign dcache_rdata = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory commands and cache responses are queued
// by the stimulus; a memory responder and a response monitor pop and compare independently.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         icache_read = 1'b0;
    logic [31:0]  icache_address = '0;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read = 1'b0;
    logic         dcache_write = 1'b0;
    logic [31:0]  dcache_address = '0;
    logic [255:0] dcache_wdata = '0;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic [255:0] rdata;
    } resp_t;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int unsigned  delay;
        logic [255:0] rdata;
    } mem_t;

    resp_t resp_q[$];
    mem_t  mem_q[$];

    int checks   = 0;
    int failures = 0;

    logic        force_resp = 1'b0;
    logic        mem_busy   = 1'b0;
    int unsigned mem_cnt    = 0;
    mem_t        cur;
    resp_t       r;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                            input int unsigned delay, input logic [255:0] rdata);
        mem_t m;
        m.wr = wr; m.addr = addr; m.wdata = wdata; m.delay = delay; m.rdata = rdata;
        mem_q.push_back(m);
    endtask

    task automatic push_resp(input logic is_d, input logic [255:0] rdata);
        resp_t e;
        e.is_d = is_d; e.rdata = rdata;
        resp_q.push_back(e);
    endtask

    // Returns at posedge+1 after the selected resp pulse has been seen.
    task automatic wait_resp(input logic is_d, input string name);
        int unsigned n = 0;
        while (!(is_d ? dcache_resp : icache_resp) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: no resp within 50 cycles, required one pulse", name);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && (icache_resp || dcache_resp)) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {icache_resp, dcache_resp}, 2'b00);
            end else begin
                r = resp_q.pop_front();
                chk("resp_port", {icache_resp, dcache_resp}, r.is_d ? 2'b01 : 2'b10);
                chk("resp_rdata", r.is_d ? dcache_rdata : icache_rdata, r.rdata);
            end
        end
    end

    // Memory responder: checks each command against the queue and answers after cm.delay cycles.
    always @(negedge clk) begin
        pmem_resp = force_resp;
        if (rst) begin
            mem_busy = 1'b0;
        end else if (pmem_read || pmem_write) begin
            if (!mem_busy) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
                end else begin
                    cur      = mem_q.pop_front();
                    mem_busy = 1'b1;
                    mem_cnt  = 0;
                    chk("pmem_cmd", {pmem_read, pmem_write}, cur.wr ? 2'b01 : 2'b10);
                end
            end
            if (mem_busy) begin
                chk("pmem_address", pmem_address, cur.addr);
                if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
                mem_cnt++;
                if (mem_cnt == cur.delay) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = cur.rdata;
                    mem_busy   = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [255:0] line_a;
        logic [255:0] line_5;
        int unsigned  n;
        line_a = {8{32'hAAAA_AAAA}};
        line_5 = {8{32'h5555_5555}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pmem_read",    pmem_read,    0);
        chk("rst_pmem_write",   pmem_write,   0);
        chk("rst_icache_resp",  icache_resp,  0);
        chk("rst_dcache_resp",  dcache_resp,  0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata",   pmem_wdata,   0);
        chk("rst_icache_rdata", icache_rdata, 0);
        chk("rst_dcache_rdata", dcache_rdata, 0);
        @(posedge clk);
        #1;

        // icache read, memory answers in the 4th command cycle.
        push_mem(1'b0, 32'h0000_1220, '0, 4, line_a);
        push_resp(1'b0, line_a);
        icache_read    = 1'b1;
        icache_address = 32'h0000_1234;
        wait_resp(1'b0, "icache_read");
        icache_read = 1'b0;

        // dcache write; the line buffer must still hold line_a.
        push_mem(1'b1, 32'h8000_0040, line_5, 2, {8{32'hDEAD_BEEF}});
        push_resp(1'b1, line_a);
        dcache_write   = 1'b1;
        dcache_address = 32'h8000_0040;
        dcache_wdata   = line_5;
        wait_resp(1'b1, "dcache_write");
        dcache_write = 1'b0;

        // Three simultaneous icache/dcache read pairs: D then I each time.
        for (int unsigned p = 0; p < 3; p++) begin
            push_mem(1'b0, 32'h0000_2000 + p * 32'h100, '0, 1, {8{32'h1111_0000 + p}});
            push_mem(1'b0, 32'h0000_3000 + p * 32'h100, '0, 3, {8{32'h2222_0000 + p}});
            push_resp(1'b1, {8{32'h1111_0000 + p}});
            push_resp(1'b0, {8{32'h2222_0000 + p}});
            dcache_read    = 1'b1;
            dcache_address = 32'h0000_2000 + p * 32'h100 + 32'h1C;
            icache_read    = 1'b1;
            icache_address = 32'h0000_3000 + p * 32'h100 + 32'h04;
            wait_resp(1'b1, "pair_d");
            dcache_read = 1'b0;
            wait_resp(1'b0, "pair_i");
            icache_read = 1'b0;
            @(posedge clk);
            #1;
        end

        // Stray pmem_resp in IDLE.
        force_resp = 1'b1;
        @(posedge clk);
        #1 force_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_idle_outputs", {pmem_read, pmem_write, icache_resp, dcache_resp}, 4'b0000);
        @(posedge clk);
        #1;

        // Reset two cycles into a D_READ, then a late pmem_resp.
        push_mem(1'b0, 32'h0000_4000, '0, 100, {8{32'hBAD0_BAD0}});
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_4010;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        dcache_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        force_resp = 1'b1;
        @(negedge clk);
        chk("post_rst_pmem_read",   pmem_read,    0);
        chk("post_rst_dcache_resp", dcache_resp,  0);
        chk("post_rst_address",     pmem_address, 0);
        @(posedge clk);
        #1 force_resp = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_outputs", {pmem_read, pmem_write, icache_resp, dcache_resp}, 4'b0000);
        @(posedge clk);
        #1;

        // Read and write together: serviced as a write; line buffer was cleared by reset.
        push_mem(1'b1, 32'h0000_5000, {8{32'hC3C3_C3C3}}, 1, {8{32'h7777_7777}});
        push_resp(1'b1, '0);
        dcache_read    = 1'b1;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_5008;
        dcache_wdata   = {8{32'hC3C3_C3C3}};
        wait_resp(1'b1, "rd_wr_both");
        dcache_read  = 1'b0;
        dcache_write = 1'b0;

        n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d resp and %0d mem entries left, required 0", resp_q.size(), mem_q.size());
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
